// File: rtl/relogio_xadrez_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | relogio_xadrez_core                                                        |
// | Two-player chess clock: BCD mm:ss countdown, turn swaps, flagging and an   |
// | 8-digit multiplexed seven-segment driver. Optional RELOGIO_INCREMENT_EN    |
// | adds 2 s to the player who ends a turn.                                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module relogio_xadrez_core #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int SCAN_DIV   = 100_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carga,
    input  logic       j1,
    input  logic       j2,
    input  logic [6:0] chaves,
    output logic [7:0] an,
    output logic [7:0] dec_ddp
);

    localparam int PRE_W  = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLOCK_FREQ - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN1   = 3'd2,
        RUN2   = 3'd3,
        END1   = 3'd4,
        END2   = 3'd5
    } state_t;

    // Bits [1:0] are the synchronizer stages, bit [2] holds the previous synced value.
    logic [2:0] carga_q, j1_q, j2_q;
    logic       carga_ev, j1_ev, j2_ev;

    state_t            state_q, state_d;
    logic [15:0]       t1_q, t1_d, t2_q, t2_d;
    logic [PRE_W-1:0]  pre_q, pre_d;

    logic [SCAN_W-1:0] scan_cnt_q;
    logic [2:0]        idx_q;
    logic [7:0]        an_q, seg_q;
    logic [7:0]        an_d, seg_d;
    logic [3:0]        digit;
    logic              dp_on;

    function automatic logic [15:0] load_value(input logic [6:0] m);
        logic [6:0] v;
        v = (m > 7'd99) ? 7'd99 : m;
        return {4'(v / 7'd10), 4'(v % 7'd10), 8'h00};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else if (t[15:8] != 8'h00) begin
            r[7:0] = 8'h59;
            if (t[11:8] != 4'd0) begin
                r[11:8] = t[11:8] - 4'd1;
            end else begin
                r[11:8]  = 4'd9;
                r[15:12] = t[15:12] - 4'd1;
            end
        end
        return r;
    endfunction

`ifdef RELOGIO_INCREMENT_EN
    function automatic logic [15:0] bcd_inc2(input logic [15:0] t);
        logic [15:0] r;
        logic [4:0]  s1;
        r  = t;
        s1 = {1'b0, t[3:0]} + 5'd2;
        if (t[15:4] == 12'h995 && t[3:0] >= 4'd8) begin
            r = 16'h9959;
        end else if (s1 >= 5'd10) begin
            r[3:0] = 4'(s1 - 5'd10);
            if (t[7:4] == 4'd5) begin
                r[7:4] = 4'd0;
                if (t[11:8] == 4'd9) begin
                    r[11:8]  = 4'd0;
                    r[15:12] = t[15:12] + 4'd1;
                end else begin
                    r[11:8] = t[11:8] + 4'd1;
                end
            end else begin
                r[7:4] = t[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = s1[3:0];
        end
        return r;
    endfunction
`endif

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h03;
            4'd1:    return 8'h9F;
            4'd2:    return 8'h25;
            4'd3:    return 8'h0D;
            4'd4:    return 8'h99;
            4'd5:    return 8'h49;
            4'd6:    return 8'h41;
            4'd7:    return 8'h1F;
            4'd8:    return 8'h01;
            4'd9:    return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    assign carga_ev = carga_q[1] & ~carga_q[2];
    assign j1_ev    = j1_q[1] & ~j1_q[2];
    assign j2_ev    = j2_q[1] & ~j2_q[2];

    always_comb begin
        state_d = state_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        pre_d   = pre_q;
        if (carga_ev) begin
            state_d = LOADED;
            t1_d    = load_value(chaves);
            t2_d    = load_value(chaves);
            pre_d   = '0;
        end else begin
            case (state_q)
                LOADED: begin
                    if (j2_ev && !j1_ev) begin
                        state_d = RUN1;
                        pre_d   = '0;
                    end else if (j1_ev && !j2_ev) begin
                        state_d = RUN2;
                        pre_d   = '0;
                    end
                end
                RUN1: begin
                    if (t1_q == 16'h0000) begin
                        state_d = END1;
                    end else if (j1_ev) begin
                        state_d = RUN2;
                        pre_d   = '0;
`ifdef RELOGIO_INCREMENT_EN
                        t1_d    = bcd_inc2(t1_q);
`endif
                    end else if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        t1_d  = bcd_dec(t1_q);
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                RUN2: begin
                    if (t2_q == 16'h0000) begin
                        state_d = END2;
                    end else if (j2_ev) begin
                        state_d = RUN1;
                        pre_d   = '0;
`ifdef RELOGIO_INCREMENT_EN
                        t2_d    = bcd_inc2(t2_q);
`endif
                    end else if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        t2_d  = bcd_dec(t2_q);
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx_q)
            3'd7: digit = t1_q[15:12];
            3'd6: digit = t1_q[11:8];
            3'd5: digit = t1_q[7:4];
            3'd4: digit = t1_q[3:0];
            3'd3: digit = t2_q[15:12];
            3'd2: digit = t2_q[11:8];
            3'd1: digit = t2_q[7:4];
            3'd0: digit = t2_q[3:0];
            default: digit = 4'd0;
        endcase
        // Separator dps on 6 and 2; a flagged player's whole half lights its dps.
        dp_on = (idx_q == 3'd6) || (idx_q == 3'd2) ||
                (state_q == END1 && idx_q[2]) || (state_q == END2 && !idx_q[2]);
        seg_d = seg7(digit) & ~{7'b0000000, dp_on};
        an_d  = ~(8'd1 << idx_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            carga_q    <= 3'b000;
            j1_q       <= 3'b000;
            j2_q       <= 3'b000;
            state_q    <= IDLE;
            t1_q       <= 16'h0000;
            t2_q       <= 16'h0000;
            pre_q      <= '0;
            scan_cnt_q <= '0;
            idx_q      <= 3'd0;
            an_q       <= 8'hFF;
            seg_q      <= 8'hFF;
        end else begin
            carga_q <= {carga_q[1:0], carga};
            j1_q    <= {j1_q[1:0], j1};
            j2_q    <= {j2_q[1:0], j2};
            state_q <= state_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            pre_q   <= pre_d;
            if (scan_cnt_q == SCAN_MAX) begin
                scan_cnt_q <= '0;
                idx_q      <= idx_q + 3'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an      = an_q;
    assign dec_ddp = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_relogio_xadrez_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_relogio_xadrez_core                                                     |
// | Seconds-based reference model of the chess clock compared every cycle.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_relogio_xadrez_core;

    localparam int CF = 4;
    localparam int SD = 1;
    localparam int S_IDLE = 0, S_LOADED = 1, S_RUN1 = 2, S_RUN2 = 3, S_END1 = 4, S_END2 = 5;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       carga  = 1'b0;
    logic       j1     = 1'b0;
    logic       j2     = 1'b0;
    logic [6:0] chaves = 7'd0;
    logic [7:0] an, dec_ddp;

    int checks   = 0;
    int failures = 0;

    relogio_xadrez_core #(.CLOCK_FREQ(CF), .SCAN_DIV(SD)) dut (
        .clock   (clock),
        .reset   (reset),
        .carga   (carga),
        .j1      (j1),
        .j2      (j2),
        .chaves  (chaves),
        .an      (an),
        .dec_ddp (dec_ddp)
    );

    always #5 clock = ~clock;

    logic [7:0] seg_tab [0:9] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                  8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    // Model: times in plain seconds, input history as sampled at each edge.
    int         m_state, m_t1, m_t2, m_pre, m_cyc, m_idx, m_load;
    logic [2:0] hc, h1, h2;
    logic       ec, e1, e2;
    logic [7:0] exp_an  = 8'hFF;
    logic [7:0] exp_dec = 8'hFF;

    function automatic logic [7:0] disp(input int idx, input int t1, input int t2, input int st);
        int t, d;
        logic [7:0] s;
        t = (idx >= 4) ? t1 : t2;
        case (idx % 4)
            3:       d = (t / 60) / 10;
            2:       d = (t / 60) % 10;
            1:       d = (t % 60) / 10;
            default: d = (t % 60) % 10;
        endcase
        s = seg_tab[d];
        if (idx == 6 || idx == 2 || (st == S_END1 && idx >= 4) || (st == S_END2 && idx < 4))
            s[0] = 1'b0;
        return s;
    endfunction

    function automatic int add_inc(input int t);
`ifdef RELOGIO_INCREMENT_EN
        return (t + 2 > 5999) ? 5999 : t + 2;
`else
        return t;
`endif
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_state = S_IDLE; m_t1 = 0; m_t2 = 0; m_pre = 0; m_cyc = 0;
            hc = 3'b000; h1 = 3'b000; h2 = 3'b000;
            exp_an = 8'hFF; exp_dec = 8'hFF;
        end else begin
            m_idx   = (m_cyc / SD) % 8;
            exp_an  = ~(8'd1 << m_idx);
            exp_dec = disp(m_idx, m_t1, m_t2, m_state);
            m_cyc   = m_cyc + 1;
            ec = hc[1] & ~hc[2];
            e1 = h1[1] & ~h1[2];
            e2 = h2[1] & ~h2[2];
            hc = {hc[1:0], carga};
            h1 = {h1[1:0], j1};
            h2 = {h2[1:0], j2};
            m_load = ((chaves > 7'd99) ? 99 : int'(chaves)) * 60;
            if (ec) begin
                m_state = S_LOADED; m_t1 = m_load; m_t2 = m_load; m_pre = 0;
            end else if (m_state == S_LOADED) begin
                if (e2 && !e1)      begin m_state = S_RUN1; m_pre = 0; end
                else if (e1 && !e2) begin m_state = S_RUN2; m_pre = 0; end
            end else if (m_state == S_RUN1) begin
                if (m_t1 == 0)             m_state = S_END1;
                else if (e1)               begin m_state = S_RUN2; m_pre = 0; m_t1 = add_inc(m_t1); end
                else if (m_pre == CF - 1)  begin m_pre = 0; m_t1 = m_t1 - 1; end
                else                       m_pre = m_pre + 1;
            end else if (m_state == S_RUN2) begin
                if (m_t2 == 0)             m_state = S_END2;
                else if (e2)               begin m_state = S_RUN1; m_pre = 0; m_t2 = add_inc(m_t2); end
                else if (m_pre == CF - 1)  begin m_pre = 0; m_t2 = m_t2 - 1; end
                else                       m_pre = m_pre + 1;
            end
        end
    end

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            checks++;
            if (an !== exp_an || dec_ddp !== exp_dec) begin
                failures++;
                if (failures < 20)
                    $display("FAIL cycle_cmp t=%0t an=%h dec_ddp=%h required an=%h dec_ddp=%h",
                             $time, an, dec_ddp, exp_an, exp_dec);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic digit(input int d, output logic [7:0] v);
        logic [7:0] sel;
        sel = ~(8'd1 << d);
        v   = 8'hxx;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (an == sel) begin
                v = dec_ddp;
                break;
            end
        end
    endtask

    task automatic chk_digit(input string name, input int d, input logic [7:0] req);
        logic [7:0] v;
        digit(d, v);
        chk(name, {24'd0, v}, {24'd0, req});
    endtask

    // Hold for three cycles: the state change lands on the last edge before return.
    task automatic press(input int which);
        @(negedge clock);
        if (which == 0) carga = 1'b1; else if (which == 1) j1 = 1'b1; else j2 = 1'b1;
        repeat (3) @(negedge clock);
        carga = 1'b0; j1 = 1'b0; j2 = 1'b0;
    endtask

    task automatic wait_state(input string name, input int s, input int bound);
        int k;
        k = 0;
        while (m_state != s && k < bound) begin
            @(negedge clock);
            k++;
        end
        chk(name, m_state, s);
    endtask

    initial begin
        int r;
        repeat (3) @(negedge clock);
        chk("reset_an", {24'd0, an}, 32'hFF);
        chk("reset_dec", {24'd0, dec_ddp}, 32'hFF);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        chk_digit("idle_d0", 0, 8'h03);
        chk_digit("idle_d6", 6, 8'h02);
        press(1);
        press(2);
        repeat (10) @(negedge clock);
        chk("idle_ignores", m_state, S_IDLE);
        chk_digit("idle_d7", 7, 8'h03);

        chaves = 7'd5;
        press(0);
        chk("load5_state", m_state, S_LOADED);
        chk("load5_t1", m_t1, 300);
        repeat (100) @(negedge clock);
        chk_digit("load5_d6", 6, 8'h48);
        chk_digit("load5_d4", 4, 8'h03);
        chk("load5_t2", m_t2, 300);

        chaves = 7'd120;
        press(0);
        chk("sat_t1", m_t1, 5940);
        chk_digit("sat_d7", 7, 8'h09);
        chk_digit("sat_d6", 6, 8'h08);

        chaves = 7'd5;
        press(0);
        press(2);
        chk("run1_state", m_state, S_RUN1);
        repeat (4) @(negedge clock);
        chk("run1_first_dec", m_t1, 299);
        repeat (236) @(negedge clock);
        chk("run1_240", m_t1, 240);
        chk("run1_t2_frozen", m_t2, 300);
        press(2);
        chk("run1_ignore_j2", m_state, S_RUN1);
        press(1);
        chk("swap_run2", m_state, S_RUN2);
        repeat (4) @(negedge clock);
        chk("run2_first_dec", m_t2, 299);

        chaves = 7'd1;
        press(0);
        press(2);
        wait_state("end1_state", S_END1, 300);
        chk("end1_t1", m_t1, 0);
        chk("end1_t2", m_t2, 60);
        chk_digit("end1_d7", 7, 8'h02);
        chk_digit("end1_d5", 5, 8'h02);
        chk_digit("end1_d3", 3, 8'h03);
        chk_digit("end1_d2", 2, 8'h9E);
        press(0);
        chk("reload_state", m_state, S_LOADED);

        chaves = 7'd3;
        @(negedge clock);
        carga = 1'b1; j1 = 1'b1;
        repeat (3) @(negedge clock);
        carga = 1'b0; j1 = 1'b0;
        repeat (20) @(negedge clock);
        chk("simul_state", m_state, S_LOADED);
        chk("simul_t1", m_t1, 180);
        chk_digit("simul_d6", 6, 8'h0C);

        chaves = 7'd0;
        press(0);
        press(1);
        repeat (2) @(negedge clock);
        chk("zero_end2", m_state, S_END2);
        chk_digit("zero_d0", 0, 8'h02);

        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            r = $urandom_range(0, 199);
            if (r < 2)       carga = ~carga;
            else if (r < 22) j1 = ~j1;
            else if (r < 42) j2 = ~j2;
            if ($urandom_range(0, 40) == 0)
                chaves = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127))
                                                     : 7'($urandom_range(0, 2));
            if (i == 3000) begin
                @(posedge clock);
                #2;
                reset = 1'b0;
                #1;
                chk("async_reset_an", {24'd0, an}, 32'hFF);
                chk("async_reset_dec", {24'd0, dec_ddp}, 32'hFF);
                repeat (2) @(negedge clock);
                reset = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
